// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Raster constants shared by vga_timing and img_generator, so that both
//   agree on the visible frame size. It also holds the default porch and
//   sync lengths for 640x480 at 60 Hz, and the counter width.
package vga_timing_pkg;

    localparam int CNT_W        = 12;

    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;

    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Total period of one axis (active + front porch + sync + back porch).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing
//   Generates VGA raster timing from the pixel clock. It publishes 1-based
//   pixel coordinates to img_generator, then registers the returned colour.
//   Colour, blank and both syncs share one output register stage, so they
//   stay aligned at the pins. It also emits a one-cycle tick at the start of
//   vertical blanking.
//
// Ports
//   CLOCK_25     in   pixel clock, rising edge
//   reset_n      in   synchronous active-low reset
//   color_in     in   [2]=R [1]=G [0]=B from img_generator (combinational on x/y)
//   x, y         out  1-based column/row while active, 0 in blanking
//   VGA_R/G/B    out  channel bit replicated to DAC_WIDTH, 0 when blanked
//   VGA_HS/VS    out  syncs, asserted level SYNC_ACTIVE
//   VGA_BLANK_N  out  high on active pixels
//   frame_tick   out  one-cycle pulse at start of vertical blanking
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = FRAME_WIDTH,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_ACTIVE    = FRAME_HEIGHT,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   DAC_WIDTH   = 4
) (
    input  logic                 CLOCK_25,
    input  logic                 reset_n,
    input  logic [2:0]           color_in,
    output logic [11:0]          x,
    output logic [11:0]          y,
    output logic [DAC_WIDTH-1:0] VGA_R,
    output logic [DAC_WIDTH-1:0] VGA_G,
    output logic [DAC_WIDTH-1:0] VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK_N,
    output logic                 frame_tick
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL >= 4096 || V_TOTAL >= 4096) begin : g_bad_total
            $error("vga_timing: H_TOTAL/V_TOTAL must fit the 12-bit counters");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_active;
    logic             w_active_nxt;
    logic [11:0]      w_x_nxt;
    logic [11:0]      w_y_nxt;
    logic             w_hs_win;
    logic             w_vs_win;

    // Next-state counters. x/y are registered from these so that they move
    // on the same edge as the counters themselves.
    always_comb begin
        w_h_nxt = r_h_cnt + 1'b1;
        w_v_nxt = r_v_cnt;
        if (r_h_cnt == H_MAX) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v_cnt == V_MAX) ? '0 : r_v_cnt + 1'b1;
        end
    end

    always_comb begin
        w_active     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_active_nxt = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        w_x_nxt      = w_active_nxt ? w_h_nxt + 12'd1 : '0;
        w_y_nxt      = w_active_nxt ? w_v_nxt + 12'd1 : '0;
        w_hs_win     = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
        w_vs_win     = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
    end

    // Counters and coordinates. Reset parks the counters at the frame end,
    // so the first released edge wraps them to (0,0).
    always_ff @(posedge CLOCK_25) begin
        if (!reset_n) begin
            r_h_cnt <= H_MAX;
            r_v_cnt <= V_MAX;
            x       <= '0;
            y       <= '0;
        end else begin
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            x       <= w_x_nxt;
            y       <= w_y_nxt;
        end
    end

    // Output stage, one cycle behind x/y. The active flag masks color_in,
    // so unknown colour values during blanking never reach the DAC.
    always_ff @(posedge CLOCK_25) begin
        if (!reset_n) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= ~SYNC_ACTIVE;
            VGA_VS      <= ~SYNC_ACTIVE;
            frame_tick  <= 1'b0;
        end else begin
            VGA_R       <= {DAC_WIDTH{color_in[2] & w_active}};
            VGA_G       <= {DAC_WIDTH{color_in[1] & w_active}};
            VGA_B       <= {DAC_WIDTH{color_in[0] & w_active}};
            VGA_BLANK_N <= w_active;
            VGA_HS      <= w_hs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            VGA_VS      <= w_vs_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            frame_tick  <= (r_h_cnt == '0) && (r_v_cnt == V_ACT);
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
//   Directed bench for vga_timing. Instance u_full runs the default
//   640x480 timing; it covers reset values, coordinate sequencing, line
//   timing and colour latency over the first two lines. Instance u_small uses
//   a shrunken raster (25x19 totals, active-high syncs), so whole frames and
//   a mid-frame reset fit a short run.
module tb_vga_timing;

    logic        clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst_a, rst_b;
    logic [2:0]  col_a, col_b;
    logic [11:0] xa, ya, xb, yb;
    logic [3:0]  ra, ga, ba, rb, gb, bb;
    logic        hsa, vsa, bla, fta, hsb, vsb, blb, ftb;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing u_full (
        .CLOCK_25(clk), .reset_n(rst_a), .color_in(col_a), .x(xa), .y(ya),
        .VGA_R(ra), .VGA_G(ga), .VGA_B(ba), .VGA_HS(hsa), .VGA_VS(vsa),
        .VGA_BLANK_N(bla), .frame_tick(fta)
    );

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_ACTIVE(1'b1), .DAC_WIDTH(4)
    ) u_small (
        .CLOCK_25(clk), .reset_n(rst_b), .color_in(col_b), .x(xb), .y(yb),
        .VGA_R(rb), .VGA_G(gb), .VGA_B(bb), .VGA_HS(hsb), .VGA_VS(vsb),
        .VGA_BLANK_N(blb), .frame_tick(ftb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one pixel clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   hs_fall1, hs_fall2, hs_low, ones, ones_k, leak;
        logic hs_prev;
        int   lit, blanks, vs_cnt, vs_rise, hs_rise, tick_n, tick1, tick2;
        logic vs_prev, hsb_prev;
        int   found, k_vs;

        rst_a = 1'b0; rst_b = 1'b0; col_a = 3'b000; col_b = 3'b000;

        // ---------------- full-size instance ----------------
        repeat (5) step();
        check("a_rst_x", xa, 0);
        check("a_rst_y", ya, 0);
        check("a_rst_rgb", {ra, ga, ba}, 0);
        check("a_rst_hs", hsa, 1);
        check("a_rst_vs", vsa, 1);
        check("a_rst_blank", bla, 0);
        check("a_rst_tick", fta, 0);

        rst_a = 1'b1;
        step();                                   // k = 0: counters at (0,0)
        check("a_first_x", xa, 1);
        check("a_first_y", ya, 1);

        hs_fall1 = -1; hs_fall2 = -1; hs_low = 0; ones = 0; ones_k = -1; leak = 0;
        hs_prev = hsa;
        for (int k = 1; k < 1700; k++) begin
            step();
            if (k == 1)   check("a_second_x", xa, 2);
            if (k == 639) check("a_x_last", xa, 640);
            if (k == 640) check("a_x_hblank", xa, 0);
            if (k == 800) begin
                check("a_line2_x", xa, 1);
                check("a_line2_y", ya, 2);
            end
            if (hs_prev && !hsa) begin
                if (hs_fall1 < 0) hs_fall1 = k;
                else if (hs_fall2 < 0) hs_fall2 = k;
            end
            if (k < 800 && !hsa) hs_low++;
            if ({ra, ga, ba} == 12'hFFF) begin
                ones++;
                ones_k = k;
            end
            if (!bla && ({ra, ga, ba} !== 12'h000)) leak++;
            hs_prev = hsa;
            // img_generator stand-in: white only at (5,1), unknown in blanking
            col_a = (xa == 12'd5 && ya == 12'd1) ? 3'b111 :
                    (xa == 12'd0 ? 3'bxxx : 3'b000);
        end
        check("a_hs_fall", hs_fall1, 657);
        check("a_hs_period", hs_fall2 - hs_fall1, 800);
        check("a_hs_low", hs_low, 96);
        check("a_lat_count", ones, 1);
        check("a_lat_cycle", ones_k, 5);
        check("a_blank_leak", leak, 0);
        check("a_vs_idle", vsa, 1);

        // ---------------- small instance: whole frames ----------------
        col_b = 3'b101;
        step(); step();
        check("b_rst_hs", hsb, 0);
        check("b_rst_vs", vsb, 0);
        rst_b = 1'b1;

        lit = 0; blanks = 0; vs_cnt = 0; vs_rise = -1; hs_rise = -1;
        tick_n = 0; tick1 = -1; tick2 = -1; leak = 0;
        vs_prev = 1'b0; hsb_prev = 1'b0;
        for (int k = 0; k < 950; k++) begin
            step();
            if (k == 0) begin
                check("b_first_x", xb, 1);
                check("b_first_y", yb, 1);
            end
            if (k < 475) begin
                if (rb == 4'hF && gb == 4'h0 && bb == 4'hF && blb) lit++;
                if (blb) blanks++;
                if (!blb && ({rb, gb, bb} != 12'h000)) leak++;
                if (vsb) vs_cnt++;
            end
            if (!vs_prev && vsb && vs_rise < 0) vs_rise = k;
            if (!hsb_prev && hsb && hs_rise < 0) hs_rise = k;
            if (ftb) begin
                tick_n++;
                if (tick1 < 0) tick1 = k;
                else if (tick2 < 0) tick2 = k;
            end
            vs_prev = vsb;
            hsb_prev = hsb;
        end
        check("b_lit_pixels", lit, 192);
        check("b_blank_n_count", blanks, 192);
        check("b_blank_leak", leak, 0);
        check("b_vs_width", vs_cnt, 50);
        check("b_vs_rise", vs_rise, 351);
        check("b_hs_rise", hs_rise, 19);
        check("b_tick_count", tick_n, 2);
        check("b_tick_first", tick1, 301);
        check("b_tick_period", tick2 - tick1, 475);

        // ---------------- small instance: mid-frame reset ----------------
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            if (xb == 12'd10 && yb == 12'd7) found = 1;
            else step();
        end
        check("b_find_10_7", found, 1);
        rst_b = 1'b0;
        step();
        check("b_mrst_x", xb, 0);
        check("b_mrst_y", yb, 0);
        check("b_mrst_rgb", {rb, gb, bb}, 0);
        check("b_mrst_blank", blb, 0);
        check("b_mrst_hs", hsb, 0);
        check("b_mrst_vs", vsb, 0);
        check("b_mrst_tick", ftb, 0);
        rst_b = 1'b1;
        step();                                   // release edge, counters (0,0)
        check("b_restart_x", xb, 1);
        check("b_restart_y", yb, 1);
        k_vs = -1;
        for (int k = 1; k < 600 && k_vs < 0; k++) begin
            step();
            if (vsb) k_vs = k;
        end
        check("b_restart_vs", k_vs, 351);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
